// File: rtl/instr_fetch.sv
// Fetch stage: registered read of the instruction memory at PC, with a one-cycle
// bubble after a redirect, a halt freeze, a memory load port and saturating counters.
module instr_fetch #(
  parameter int             AW        = 10,
  parameter int             IW        = 9,
  parameter int             DEPTH     = 1024,
  parameter logic [IW-1:0]  NOP_INSTR = '0,
  parameter int             CW        = 16
) (
  input  logic          CLK,
  input  logic          init,
  input  logic [AW-1:0] PC,
  input  logic          halt,
  input  logic          redirect,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  output logic          wr_ack,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic          fetch_done,
  output logic          oob_err,
  output logic [CW-1:0] cycle_ct,
  output logic [CW-1:0] instr_ct
);

  localparam int              LW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   CT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] mem [DEPTH];

  logic          pc_oob, wr_in_range;
  logic [LW-1:0] rd_idx, wr_idx;
  logic          fetch_next, issue_next, count_next, write_next;

  assign pc_oob      = ({1'b0, PC} >= DEPTH_W);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_idx      = PC[LW-1:0];
  assign wr_idx      = wr_addr[LW-1:0];

  // RUN and FLUSH act alike on the edge; FLUSH only marks that the bubble is on the output.
  always_comb begin
    state_next = state_reg;
    fetch_next = 1'b0;
    issue_next = 1'b0;
    count_next = 1'b0;
    write_next = 1'b0;
    case (state_reg)
      IDLE: begin
        write_next = wr_en && wr_in_range;
        if (halt)        state_next = HALTED;
        else if (!wr_en) state_next = RUN;
      end
      RUN, FLUSH: begin
        if (halt) begin
          state_next = HALTED;
        end else begin
          fetch_next = 1'b1;
          count_next = 1'b1;
          if (redirect) begin
            state_next = FLUSH;
          end else begin
            state_next = RUN;
            issue_next = 1'b1;
          end
        end
      end
      HALTED: begin
        write_next = wr_en && wr_in_range;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (init) begin
      state_reg   <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_done  <= 1'b0;
      oob_err     <= 1'b0;
      wr_ack      <= 1'b0;
      cycle_ct    <= '0;
      instr_ct    <= '0;
    end else begin
      state_reg   <= state_next;
      instr_valid <= issue_next;
      fetch_done  <= (state_next == HALTED);
      wr_ack      <= write_next;
      if (fetch_next) begin
        instr <= pc_oob ? NOP_INSTR : mem[rd_idx];
        if (pc_oob) oob_err <= 1'b1;
      end
      if (count_next && cycle_ct != CT_MAX) cycle_ct <= cycle_ct + 1'b1;
      if (issue_next && instr_ct != CT_MAX) instr_ct <= instr_ct + 1'b1;
    end
  end

  // Contents survive init, so the array has no reset.
  always_ff @(posedge CLK) begin
    if (!init && write_next) mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the main sequences plus
// hand-written loops for counter saturation and reset out of RUN.
module tb_instr_fetch;

  logic       CLK;
  logic       init, halt, redirect, wr_en;
  logic [9:0] PC, wr_addr;
  logic [8:0] wr_data;
  logic       wr_ack, instr_valid, fetch_done, oob_err;
  logic [8:0] instr;
  logic [3:0] cycle_ct, instr_ct;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .AW(10), .IW(9), .DEPTH(64), .NOP_INSTR(9'h000), .CW(4)
  ) dut (
    .CLK(CLK), .init(init), .PC(PC), .halt(halt), .redirect(redirect),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .instr(instr), .instr_valid(instr_valid), .fetch_done(fetch_done),
    .oob_err(oob_err), .cycle_ct(cycle_ct), .instr_ct(instr_ct)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       init;
    logic [9:0] pc;
    logic       halt, redir, wr_en;
    logic [9:0] wa;
    logic [8:0] wd;
    logic       e_ack;
    logic [8:0] e_instr;
    logic       ci;
    logic       e_valid, e_done, e_oob;
    logic [3:0] e_cyc, e_ic;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input int i_init, input int pc, input int hl, input int rd,
                      input int we, input int wa, input int wd,
                      input int ack, input int ins, input int ci, input int vld,
                      input int dn, input int oob, input int cyc, input int ic);
    vec_t v;
    v.init = (i_init != 0); v.pc = 10'(pc); v.halt = (hl != 0); v.redir = (rd != 0);
    v.wr_en = (we != 0); v.wa = 10'(wa); v.wd = 9'(wd);
    v.e_ack = (ack != 0); v.e_instr = 9'(ins); v.ci = (ci != 0);
    v.e_valid = (vld != 0); v.e_done = (dn != 0); v.e_oob = (oob != 0);
    v.e_cyc = 4'(cyc); v.e_ic = 4'(ic);
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic i_init, input logic [9:0] pc, input logic hl, input logic rd,
                       input logic we, input logic [9:0] wa, input logic [8:0] wd);
    @(negedge CLK);
    init = i_init; PC = pc; halt = hl; redirect = rd; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input int idx, input logic ack, input logic [8:0] ins, input logic ci,
                            input logic vld, input logic dn, input logic oob,
                            input logic [3:0] cyc, input logic [3:0] ic);
    chk("wr_ack", idx, 32'(wr_ack), 32'(ack));
    if (ci) chk("instr", idx, 32'(instr), 32'(ins));
    chk("instr_valid", idx, 32'(instr_valid), 32'(vld));
    chk("fetch_done", idx, 32'(fetch_done), 32'(dn));
    chk("oob_err", idx, 32'(oob_err), 32'(oob));
    chk("cycle_ct", idx, 32'(cycle_ct), 32'(cyc));
    chk("instr_ct", idx, 32'(instr_ct), 32'(ic));
    $display("step %0d pc=%0d instr=%h valid=%b done=%b oob=%b cyc=%0d ic=%0d ack=%b",
             idx, PC, instr, instr_valid, fetch_done, oob_err, cycle_ct, instr_ct, wr_ack);
  endtask

  initial begin
    int         ld_a [8];
    int         ld_d [8];
    logic [8:0] prog [4];
    int         step;

    init = 1'b1; PC = '0; halt = 1'b0; redirect = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    ld_a = '{0, 1, 2, 3, 5, 12, 7, 63};
    ld_d = '{'h011, 'h022, 'h033, 'h044, 'h0AA, 'h1AB, 'h077, 'h0C3};
    prog = '{9'h011, 9'h022, 9'h033, 9'h044};

    // reset, then load program in IDLE
    addv(1, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      addv(0, 0, 0, 0, 1, ld_a[k], ld_d[k], 1, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 1, 100, 'h1FF,  0, 0, 1, 0, 0, 0, 0, 0);
    // leave IDLE, sequential fetch
    addv(0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,        0, 'h011, 1, 1, 0, 0, 1, 1);
    addv(0, 1, 0, 0, 0, 0, 0,        0, 'h022, 1, 1, 0, 0, 2, 2);
    addv(0, 2, 0, 0, 0, 0, 0,        0, 'h033, 1, 1, 0, 0, 3, 3);
    addv(0, 3, 0, 0, 0, 0, 0,        0, 'h044, 1, 1, 0, 0, 4, 4);
    // redirect at PC=5 to 12
    addv(0, 5, 0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0, 5, 4);
    addv(0, 12, 0, 0, 0, 0, 0,       0, 'h1AB, 1, 1, 0, 0, 6, 5);
    // write during RUN is ignored
    addv(0, 7, 0, 0, 1, 7, 'h155,    0, 'h077, 1, 1, 0, 0, 7, 6);
    addv(0, 7, 0, 0, 0, 0, 0,        0, 'h077, 1, 1, 0, 0, 8, 7);
    // last in-range address, then out-of-range
    addv(0, 63, 0, 0, 0, 0, 0,       0, 'h0C3, 1, 1, 0, 0, 9, 8);
    addv(0, 64, 0, 0, 0, 0, 0,       0, 'h000, 1, 1, 0, 1, 10, 9);
    addv(0, 0, 0, 0, 0, 0, 0,        0, 'h011, 1, 1, 0, 1, 11, 10);
    // halt wins over redirect, then ten frozen cycles
    addv(0, 1, 1, 1, 0, 0, 0,        0, 'h011, 1, 0, 1, 1, 11, 10);
    for (int k = 0; k < 10; k++)
      addv(0, (k * 97) % 1024, 0, k % 2, 0, 0, 0, 0, 'h011, 1, 0, 1, 1, 11, 10);
    addv(0, 0, 0, 0, 1, 7, 'h155,    1, 'h011, 1, 0, 1, 1, 11, 10);
    addv(0, 0, 0, 0, 1, 100, 'h0AA,  0, 'h011, 1, 0, 1, 1, 11, 10);
    // init overrides a concurrent write; memory survives
    addv(1, 0, 0, 0, 1, 12, 'h000,   0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 7, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 7, 0, 0, 0, 0, 0,        0, 'h155, 1, 1, 0, 0, 1, 1);
    addv(0, 12, 0, 0, 0, 0, 0,       0, 'h1AB, 1, 1, 0, 0, 2, 2);
    // redirect during FLUSH extends the bubble
    addv(0, 3, 0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0, 3, 2);
    addv(0, 5, 0, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0, 4, 2);
    addv(0, 12, 0, 0, 0, 0, 0,       0, 'h1AB, 1, 1, 0, 0, 5, 3);
    addv(0, 2, 1, 0, 0, 0, 0,        0, 'h1AB, 1, 0, 1, 0, 5, 3);
    // halt straight from IDLE
    addv(1, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 0,        0, 0, 1, 0, 1, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0);

    step = 0;
    foreach (vt[i]) begin
      drive(vt[i].init, vt[i].pc, vt[i].halt, vt[i].redir, vt[i].wr_en, vt[i].wa, vt[i].wd);
      check_outs(step, vt[i].e_ack, vt[i].e_instr, vt[i].ci, vt[i].e_valid,
                 vt[i].e_done, vt[i].e_oob, vt[i].e_cyc, vt[i].e_ic);
      step++;
    end

    // 20 RUN cycles: counters saturate at 15; last fetch is out of range
    for (int i = 0; i < 20; i++) begin
      logic [9:0] pc;
      logic [8:0] ein;
      int         sat;
      pc  = (i == 19) ? 10'd1000 : 10'(i % 4);
      ein = (i == 19) ? 9'h000 : prog[i % 4];
      sat = (i + 1 > 15) ? 15 : i + 1;
      drive(1'b0, pc, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
      check_outs(step, 1'b0, ein, 1'b1, 1'b1, 1'b0, (i == 19), 4'(sat), 4'(sat));
      step++;
    end

    // init mid-RUN clears everything, then IDLE->RUN issues nothing
    drive(1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
    check_outs(step, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step++;
    drive(1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
    check_outs(step, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step++;
    drive(1'b0, 10'd2, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0);
    check_outs(step, 1'b0, 9'h033, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter: takes the 10-bit PC and halt from the PC block and reads the instruction memory.
- Presents a registered instruction word to decode.
- Inserts a one-cycle bubble on branch/jump redirect, and freezes on halt.
- Owns the instruction memory load port used by the testbench or loader, plus fetch performance counters.

Parameters:
- AW, 10, PC / memory address width
- IW, 9, instruction word width
- DEPTH, 1024, instruction memory entries (≤ 2**AW)
- NOP_INSTR, 9'h000, word issued for an out-of-range PC
- CW, 16, performance counter width

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- init  input  1  synchronous active-high reset
- PC  input  AW  current program counter from the PC block
- halt  input  1  halt flag from the PC block
- redirect  input  1  branch or jump taken this cycle (PC changes non-sequentially)
- wr_en  input  1  instruction memory write request
- wr_addr  input  AW  write address
- wr_data  input  IW  write data
- wr_ack  output  1  one-cycle pulse: the write was accepted
- instr  output  IW  fetched instruction to decode
- instr_valid  output  1  instr is valid for decode this cycle
- fetch_done  output  1  fetch unit is in HALTED
- oob_err  output  1  sticky: an out-of-range PC was fetched
- cycle_ct  output  CW  cycles spent in RUN+FLUSH, saturating
- instr_ct  output  CW  valid instructions issued, saturating

Behaviour:
- Reset:
  - init high on a rising edge sets state=IDLE.
  - Outputs: instr=0, instr_valid=0, fetch_done=0, oob_err=0, wr_ack=0, cycle_ct=0, instr_ct=0.
  - Memory contents are NOT cleared.
  - init overrides every other input in the same cycle, including mid-RUN and mid-FLUSH.
- States: IDLE, RUN, FLUSH, HALTED. Transitions are evaluated only when init=0.
- IDLE:
  - instr_valid=0.
  - Accepts memory writes.
  - Moves to RUN on the first cycle with init=0 and wr_en=0.
  - A cycle with wr_en=1 performs the write and stays in IDLE.
- RUN, each cycle:
  - Registered read: instr <= mem[PC] on the edge, so the instruction for the PC sampled at edge N is visible after edge N (1-cycle latency).
  - instr_valid <= 1; instr_ct increments; cycle_ct increments.
  - If PC >= DEPTH: instr <= NOP_INSTR, oob_err <= 1 (sticky until init), instr_valid still 1.
- RUN with redirect=1:
  - Next state FLUSH.
  - instr_valid <= 0 for the fetched slot; instr_ct does not increment; cycle_ct increments.
- FLUSH:
  - One bubble cycle: instr_valid=0, cycle_ct increments.
  - instr is refetched from the new PC.
  - Next state RUN. A redirect during FLUSH extends FLUSH by one more cycle.
- HALTED:
  - Entered from RUN or FLUSH when halt=1.
  - halt takes priority over redirect in the same cycle.
  - instr holds its last value; instr_valid=0; fetch_done=1; counters frozen.
  - Accepts memory writes.
  - Exits only via init.
- halt=1 while in IDLE: go to HALTED directly. No fetch occurs.
- Memory write:
  - Accepted only in IDLE or HALTED when wr_en=1: mem[wr_addr] <= wr_data, wr_ack=1 the following cycle.
  - wr_addr >= DEPTH: write dropped, wr_ack stays 0.
  - wr_en in RUN/FLUSH is ignored, wr_ack=0 (no write-while-fetch hazard).
- Counters saturate at 2**CW-1 and do not wrap.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Load mem[0..3]=9'h011,9'h022,9'h033,9'h044 in IDLE (expect wr_ack pulse after each), drop wr_en, drive PC=0,1,2,3 on successive cycles -> instr=11,22,33,44 one cycle behind PC, instr_valid=1, instr_ct=4.
- In RUN at PC=5, assert redirect one cycle with PC jumping to 12 (mem[12]=9'h1AB) -> one cycle instr_valid=0, then instr=1AB valid; instr_ct excludes the flushed slot; cycle_ct counts both.
- Assert halt and redirect together in RUN -> HALTED next cycle, fetch_done=1, instr_valid=0, instr unchanged, counters frozen for 10 cycles.
- Drive PC=1023 with DEPTH=64 -> instr=NOP_INSTR, instr_valid=1, oob_err=1 and stays 1 after PC returns to 0.
- wr_en=1, wr_addr=7, wr_data=9'h155 during RUN -> wr_ack=0, mem[7] unchanged on a later fetch; the same write in HALTED -> wr_ack=1, then init and a fetch of PC=7 -> 9'h155 (memory survives reset).
- Assert init mid-RUN after 20 cycles -> next cycle state IDLE, instr=0, instr_valid=0, cycle_ct=0, instr_ct=0, oob_err=0; set CW=4 and run 20 cycles -> counters stick at 15.
